conv1d_stream_gen: RTL and testbench

CONV1D_STREAM_GEN -- requirements
Module: conv1d_stream_gen

---
 rtl/conv1d_stream_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_conv1d_stream_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_gen.sv
// -----------------------------------------------------------------------------
// conv1d_stream_gen
//   Streaming 1-D "valid" convolution. A frame of X_COUNT signed samples and a
//   filter of F_COUNT signed taps are loaded over two independent ready/valid
//   streams. The X_COUNT-F_COUNT+1 results are then computed P at a time by P
//   parallel MAC lanes and streamed out lane by lane. The filter is loaded once
//   after reset and reused for every later frame.
//   All arithmetic saturates to T bits: each product, and each running sum.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   s_data_in_x/_valid_x/_ready_x   input-vector stream (accepted in LOAD only)
//   s_data_in_f/_valid_f/_ready_f   filter stream (accepted until F_COUNT taps)
//   m_data_out_y/_valid_y/_ready_y  result stream (zero while not valid)
//   m_last_y                   marks the final result of a frame
// -----------------------------------------------------------------------------
module conv1d_stream_gen #(
   parameter int T       = 16,
   parameter int X_COUNT = 64,
   parameter int F_COUNT = 33,
   parameter int P       = 8,
   parameter int RELU    = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] s_data_in_x,
   input  logic         s_valid_x,
   output logic         s_ready_x,
   input  logic [T-1:0] s_data_in_f,
   input  logic         s_valid_f,
   output logic         s_ready_f,
   output logic [T-1:0] m_data_out_y,
   output logic         m_valid_y,
   input  logic         m_ready_y,
   output logic         m_last_y
);

   localparam int OP_COUNT = X_COUNT - F_COUNT + 1;
   localparam int G_COUNT  = OP_COUNT / P;
   localparam int XC_W     = $clog2(X_COUNT + 1);
   localparam int FC_W     = $clog2(F_COUNT + 1);
   localparam int XA_W     = (X_COUNT > 1) ? $clog2(X_COUNT) : 1;
   localparam int FA_W     = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
   localparam int G_W      = (G_COUNT > 1) ? $clog2(G_COUNT) : 1;
   localparam int L_W      = (P > 1) ? $clog2(P) : 1;

   localparam logic [T-1:0] SAT_MAX = {1'b0, {(T-1){1'b1}}};
   localparam logic [T-1:0] SAT_MIN = {1'b1, {(T-1){1'b0}}};

   if ((OP_COUNT <= 0) || ((OP_COUNT % P) != 0)) begin : g_bad_p
      $error("conv1d_stream_gen: P must divide X_COUNT-F_COUNT+1");
   end

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   // Clamp a sign-extended 2T-bit value into T bits.
   function automatic logic signed [T-1:0] sat_t(input logic signed [2*T-1:0] v);
      if ((v[2*T-1:T-1] == '0) || (v[2*T-1:T-1] == '1)) begin
         return v[T-1:0];
      end
      return v[2*T-1] ? SAT_MIN : SAT_MAX;
   endfunction

   state_t              state_q, state_d;
   logic [XC_W-1:0]     x_cnt_q, x_cnt_d;
   logic [FC_W-1:0]     f_cnt_q, f_cnt_d;
   logic                f_loaded_q, f_loaded_d;
   logic [G_W-1:0]      group_q, group_d;
   logic [L_W-1:0]      lane_q, lane_d;
   logic [FC_W-1:0]     j_q, j_d;          // next tap to fetch, F_COUNT = done
   logic                rd_v_q, rd_v_d;    // fetched operands valid this cycle
   logic                rd_last_q, rd_last_d;
   logic signed [T-1:0] acc_q [P];
   logic signed [T-1:0] acc_d [P];

   logic [T-1:0]        x_mem [X_COUNT];
   logic [T-1:0]        f_mem [F_COUNT];
   logic signed [T-1:0] x_rd_q [P];
   logic signed [T-1:0] f_rd_q;
   logic [XA_W-1:0]     x_addr [P];

   logic x_fire, f_fire, issue;
   logic signed [T-1:0] y_sel;

   assign s_ready_x = (state_q == LOAD) && (x_cnt_q != XC_W'(X_COUNT));
   assign s_ready_f = !f_loaded_q;
   assign x_fire    = s_valid_x && s_ready_x;
   assign f_fire    = s_valid_f && s_ready_f;
   assign issue     = (state_q == COMPUTE) && (j_q != FC_W'(F_COUNT));

   // Lane k of group g needs x[g*P + k + j] for tap j.
   always_comb begin
      for (int k = 0; k < P; k++) begin
         x_addr[k] = XA_W'(int'(group_q) * P + k + int'(j_q));
      end
   end

   // NOTE: sample memories and their read registers are never reset; the
   // counters and valid flags that qualify them are, which is enough to make
   // stale contents unobservable and keeps these arrays out of the reset tree.
   always_ff @(posedge clk) begin
      if (x_fire) begin
         x_mem[XA_W'(x_cnt_q)] <= s_data_in_x;
      end
      if (f_fire) begin
         f_mem[FA_W'(f_cnt_q)] <= s_data_in_f;
      end
      if (issue) begin
         for (int k = 0; k < P; k++) begin
            x_rd_q[k] <= x_mem[x_addr[k]];
         end
         f_rd_q <= f_mem[FA_W'(j_q)];
      end
   end

   always_comb begin
      logic signed [2*T-1:0] prod;
      logic signed [T-1:0]   p_sat;
      logic signed [2*T-1:0] sum;
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves one unassigned and no latch can be inferred.
      state_d    = state_q;
      x_cnt_d    = x_cnt_q;
      f_cnt_d    = f_cnt_q;
      f_loaded_d = f_loaded_q;
      group_d    = group_q;
      lane_d     = lane_q;
      j_d        = j_q;
      rd_v_d     = 1'b0;
      rd_last_d  = 1'b0;
      prod       = '0;
      p_sat      = '0;
      sum        = '0;
      for (int k = 0; k < P; k++) begin
         acc_d[k] = acc_q[k];
      end

      // Filter loading runs independently of the frame FSM.
      if (f_fire) begin
         f_cnt_d = f_cnt_q + 1'b1;
         if (f_cnt_q == FC_W'(F_COUNT - 1)) begin
            f_loaded_d = 1'b1;
         end
      end

      case (state_q)
         LOAD: begin
            if (x_fire) begin
               x_cnt_d = x_cnt_q + 1'b1;
            end
            if ((x_cnt_q == XC_W'(X_COUNT)) && f_loaded_q) begin
               state_d = COMPUTE;
               j_d     = '0;
            end
         end
         COMPUTE: begin
            // Fetch tap j this cycle; accumulate it the next cycle.
            if (issue) begin
               j_d       = j_q + 1'b1;
               rd_v_d    = 1'b1;
               rd_last_d = (j_q == FC_W'(F_COUNT - 1));
            end
            if (rd_v_q) begin
               for (int k = 0; k < P; k++) begin
                  prod     = x_rd_q[k] * f_rd_q;
                  p_sat    = sat_t(prod);
                  sum      = {{T{acc_q[k][T-1]}}, acc_q[k]} + {{T{p_sat[T-1]}}, p_sat};
                  acc_d[k] = sat_t(sum);
               end
            end
            if (rd_v_q && rd_last_q) begin
               state_d = OUTPUT;
               lane_d  = '0;
            end
         end
         OUTPUT: begin
            if (m_ready_y) begin
               if (lane_q == L_W'(P - 1)) begin
                  for (int k = 0; k < P; k++) begin
                     acc_d[k] = '0;
                  end
                  j_d = '0;
                  if (group_q == G_W'(G_COUNT - 1)) begin
                     state_d = LOAD;
                     x_cnt_d = '0;
                     group_d = '0;
                  end else begin
                     state_d = COMPUTE;
                     group_d = group_q + 1'b1;
                  end
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LOAD;
         x_cnt_q    <= '0;
         f_cnt_q    <= '0;
         f_loaded_q <= 1'b0;
         group_q    <= '0;
         lane_q     <= '0;
         j_q        <= '0;
         rd_v_q     <= 1'b0;
         rd_last_q  <= 1'b0;
         for (int k = 0; k < P; k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         x_cnt_q    <= x_cnt_d;
         f_cnt_q    <= f_cnt_d;
         f_loaded_q <= f_loaded_d;
         group_q    <= group_d;
         lane_q     <= lane_d;
         j_q        <= j_d;
         rd_v_q     <= rd_v_d;
         rd_last_q  <= rd_last_d;
         for (int k = 0; k < P; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   // Results are read straight from the accumulators, which hold still in
   // OUTPUT, so data and last are stable across backpressure.
   assign y_sel     = acc_q[lane_q];
   assign m_valid_y = (state_q == OUTPUT);
   assign m_last_y  = m_valid_y && (group_q == G_W'(G_COUNT - 1)) && (lane_q == L_W'(P - 1));

   always_comb begin
      m_data_out_y = '0;
      if (m_valid_y) begin
         if ((RELU != 0) && y_sel[T-1]) begin
            m_data_out_y = '0;
         end else begin
            m_data_out_y = y_sel;
         end
      end
   end

endmodule

// File: tb/tb_conv1d_stream_gen.sv
module tb_conv1d_stream_gen;

   localparam int T  = 16;
   localparam int XN = 8;
   localparam int FN = 3;
   localparam int PN = 2;
   localparam int ON = XN - FN + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [T-1:0] s_data_in_x, s_data_in_f;
   logic         s_valid_x, s_valid_f, m_ready_y;
   logic         s_ready_x, s_ready_f, m_valid_y, m_last_y;
   logic [T-1:0] m_data_out_y;
   logic         s_ready_x_nr, s_ready_f_nr, m_valid_y_nr, m_last_y_nr;
   logic [T-1:0] m_data_out_y_nr;

   always #5 clk = ~clk;

   conv1d_stream_gen #(.T(T), .X_COUNT(XN), .F_COUNT(FN), .P(PN), .RELU(1)) dut (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
      .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
      .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
      .m_last_y(m_last_y)
   );

   conv1d_stream_gen #(.T(T), .X_COUNT(XN), .F_COUNT(FN), .P(PN), .RELU(0)) dut_nr (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x_nr),
      .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f_nr),
      .m_data_out_y(m_data_out_y_nr), .m_valid_y(m_valid_y_nr), .m_ready_y(m_ready_y),
      .m_last_y(m_last_y_nr)
   );

   typedef struct {
      logic [T-1:0] y;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_nr_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cur_x[XN];
   int   cur_f[FN];
   bit   rand_ready = 1'b0;
   bit   gaps = 1'b0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic bound_fail(string tag);
      checks++;
      errors++;
      $error("FAIL %s: bound expired, got no event expected one", tag);
   endtask

   function automatic longint clamp(longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference convolution for the current x/f; fills both scoreboards.
   function automatic void push_frame();
      for (int i = 0; i < ON; i++) begin
         longint acc = 0;
         for (int j = 0; j < FN; j++) begin
            acc = clamp(acc + clamp(longint'(cur_x[i+j]) * longint'(cur_f[j])));
         end
         exp_nr_q.push_back('{y: T'(acc), last: (i == ON - 1)});
         if (acc < 0) exp_q.push_back('{y: '0, last: (i == ON - 1)});
         else         exp_q.push_back('{y: T'(acc), last: (i == ON - 1)});
      end
   endfunction

   task automatic send_x();
      bit done;
      int n;
      for (int i = 0; i < XN; i++) begin
         if (gaps) begin
            s_valid_x = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         s_data_in_x = T'(cur_x[i]);
         s_valid_x   = 1'b1;
         done = 1'b0;
         n = 0;
         while (!done) begin
            @(negedge clk);
            done = s_ready_x;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
               bound_fail("x_accept");
               s_valid_x = 1'b0;
               return;
            end
         end
      end
      s_valid_x = 1'b0;
   endtask

   task automatic send_f();
      bit done;
      int n;
      for (int i = 0; i < FN; i++) begin
         if (gaps) begin
            s_valid_f = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         s_data_in_f = T'(cur_f[i]);
         s_valid_f   = 1'b1;
         done = 1'b0;
         n = 0;
         while (!done) begin
            @(negedge clk);
            done = s_ready_f;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
               bound_fail("f_accept");
               s_valid_f = 1'b0;
               return;
            end
         end
      end
      s_valid_f = 1'b0;
   endtask

   task automatic do_reset();
      s_valid_x = 1'b0;
      s_valid_f = 1'b0;
      m_ready_y = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready_x", s_ready_x, 1);
      check("rst_ready_f", s_ready_f, 1);
      check("rst_valid_y", m_valid_y, 0);
      check("rst_last_y", m_last_y, 0);
      check("rst_data_y", m_data_out_y, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_nr_q.delete();
   endtask

   // Waits for the scoreboard to empty; returns just after the final transfer.
   task automatic wait_drain(string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         bound_fail(tag);
      end else begin
         check({tag, "_ready_x_after_last"}, s_ready_x, 1);
         check({tag, "_valid_after_last"}, m_valid_y, 0);
      end
   endtask

   // Output monitor, sampled on the falling edge between active edges.
   exp_t         e, en;
   bit           stall_pend = 1'b0;
   logic [T-1:0] held_y;
   logic         held_last;

   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("stall_valid", m_valid_y, 1);
            check("stall_data", m_data_out_y, held_y);
            check("stall_last", m_last_y, held_last);
         end
         stall_pend = 1'b0;
         if (m_valid_y && !m_ready_y) begin
            stall_pend = 1'b1;
            held_y     = m_data_out_y;
            held_last  = m_last_y;
         end
         if (m_valid_y && m_ready_y) begin
            if (exp_q.size() == 0 || exp_nr_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_y: got y=%0d with no result expected", $signed(m_data_out_y));
            end else begin
               e  = exp_q.pop_front();
               en = exp_nr_q.pop_front();
               check("y_data", m_data_out_y, e.y);
               check("y_last", m_last_y, e.last);
               check("nr_valid", m_valid_y_nr, 1);
               check("nr_data", m_data_out_y_nr, en.y);
               check("nr_last", m_last_y_nr, en.last);
            end
         end
         if (!m_valid_y) begin
            check("idle_data", m_data_out_y, 0);
            check("idle_last", m_last_y, 0);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         m_ready_y = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int n;
      reset       = 1'b1;
      s_valid_x   = 1'b0;
      s_valid_f   = 1'b0;
      s_data_in_x = '0;
      s_data_in_f = '0;
      m_ready_y   = 1'b0;

      // Basic frame.
      do_reset();
      cur_f = '{1, 1, 1};
      cur_x = '{1, 2, 3, 4, 5, 6, 7, 8};
      m_ready_y = 1'b1;
      push_frame();
      fork
         send_x();
         send_f();
      join
      wait_drain("basic");

      // Second frame reuses the stored filter.
      cur_x = '{8, 7, 6, 5, 4, 3, 2, 1};
      check("reuse_ready_f_before", s_ready_f, 0);
      push_frame();
      send_x();
      check("reuse_ready_f_loaded", s_ready_f, 0);
      wait_drain("reuse");
      check("reuse_ready_f_after", s_ready_f, 0);

      // Saturation of products and sums.
      do_reset();
      cur_f = '{32767, 32767, 32767};
      cur_x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      m_ready_y = 1'b1;
      push_frame();
      fork
         send_x();
         send_f();
      join
      wait_drain("sat");

      // Negative results: clamped on dut, passed through on dut_nr.
      do_reset();
      cur_f = '{-1, -1, -1};
      cur_x = '{1, 2, 3, 4, 5, 6, 7, 8};
      m_ready_y = 1'b1;
      push_frame();
      fork
         send_x();
         send_f();
      join
      wait_drain("relu");

      // Backpressure with random ready and input gaps.
      do_reset();
      cur_f = '{1, 1, 1};
      cur_x = '{1, 2, 3, 4, 5, 6, 7, 8};
      gaps       = 1'b1;
      rand_ready = 1'b1;
      push_frame();
      fork
         send_x();
         send_f();
      join
      wait_drain("bp");
      rand_ready = 1'b0;
      gaps       = 1'b0;
      @(posedge clk);
      #1;

      // Reset during the second output group.
      do_reset();
      m_ready_y = 1'b1;
      push_frame();
      fork
         send_x();
         send_f();
      join
      n = 0;
      while (exp_q.size() > ON - PN && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      m_ready_y = 1'b0;
      n = 0;
      while (!m_valid_y && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!m_valid_y) bound_fail("mid_reset_group1");
      check("mid_reset_pending", exp_q.size(), ON - PN);
      do_reset();
      m_ready_y = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("mid_reset_no_y", m_valid_y, 0);
      check("mid_reset_ready_f", s_ready_f, 1);

      // Full reload after the aborted frame.
      push_frame();
      fork
         send_x();
         send_f();
      join
      wait_drain("reload");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
